// File: rtl/nios_128k_extended_pio_pkg.sv
// Shared definitions for the extended LED PIO: register map and blink period width.
package nios_128k_extended_pio_pkg;

  localparam logic [2:0] ADDR_DATA         = 3'd0;
  localparam logic [2:0] ADDR_BLINK_MASK   = 3'd1;
  localparam logic [2:0] ADDR_BLINK_PERIOD = 3'd2;
  localparam logic [2:0] ADDR_STATUS       = 3'd3;
  localparam logic [2:0] ADDR_OUTSET       = 3'd4;
  localparam logic [2:0] ADDR_OUTCLEAR     = 3'd5;

  localparam int PERIOD_W = 16;

  // One accepted slave write, as seen by the register file.
  typedef struct packed {
    logic        wr;
    logic [2:0]  addr;
    logic [31:0] data;
  } pio_wr_t;

endpackage

// File: rtl/nios_128k_extended_blink_timer.sv
// Blink engine: free-running prescaler producing a tick every PRESCALE clocks,
// a tick counter that toggles phase every `period` ticks, and a synchronous
// clear used when software reprograms the period.
module nios_128k_extended_blink_timer
  import nios_128k_extended_pio_pkg::*;
#(
  parameter int PRESCALE = 50000
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [PERIOD_W-1:0] period,
  input  logic                clear,
  output logic                phase
);

  localparam int PW = $clog2(PRESCALE);

  logic [PW-1:0]       pre_q, pre_d;
  logic [PERIOD_W-1:0] tcnt_q, tcnt_d;
  logic                phase_q, phase_d;
  logic                tick;

  // Next-state: clear beats everything, period==0 parks the blink, else count ticks.
  always_comb begin
    tick    = (pre_q == PW'(PRESCALE - 1));
    pre_d   = tick ? '0 : pre_q + PW'(1);
    tcnt_d  = tcnt_q;
    phase_d = phase_q;
    if (clear) begin
      pre_d   = '0;
      tcnt_d  = '0;
      phase_d = 1'b0;
    end else if (period == '0) begin
      tcnt_d  = '0;
      phase_d = 1'b0;
    end else if (tick) begin
      if (tcnt_q == period - PERIOD_W'(1)) begin
        tcnt_d  = '0;
        phase_d = ~phase_q;
      end else begin
        tcnt_d  = tcnt_q + PERIOD_W'(1);
      end
    end
  end

  // Timer state flops.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pre_q   <= '0;
      tcnt_q  <= '0;
      phase_q <= 1'b0;
    end else begin
      pre_q   <= pre_d;
      tcnt_q  <= tcnt_d;
      phase_q <= phase_d;
    end
  end

  assign phase = phase_q;

endmodule

// File: rtl/nios_128k_extended_led_out.sv
// Avalon-MM LED output port with set/clear aliases and optional hardware blink.
// Build option: define LED_OUT_BLINK_EN to include the blink engine and the
// BLINK_MASK / BLINK_PERIOD / STATUS registers; otherwise out_port = DATA and
// addresses 1-3 read as zero.
module nios_128k_extended_led_out
  import nios_128k_extended_pio_pkg::*;
#(
  parameter int               WIDTH       = 4,
  parameter int               PRESCALE    = 50000,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  output logic [WIDTH-1:0] out_port
);

  pio_wr_t          req;
  logic [WIDTH-1:0] wd;
  logic [WIDTH-1:0] data_q, data_d;
  logic [31:0]      readdata_q, readdata_d;
  logic             phase;
  logic             unused_wd;

  assign req.wr   = chipselect & ~write_n;
  assign req.addr = address;
  assign req.data = writedata;
  assign wd       = req.data[WIDTH-1:0];
  assign unused_wd = ^writedata;

`ifdef LED_OUT_BLINK_EN
  logic [WIDTH-1:0]    mask_q, mask_d;
  logic [PERIOD_W-1:0] period_q, period_d;
  logic                period_wr;

  // Blink configuration registers; a period write also restarts the timer.
  always_comb begin
    mask_d    = mask_q;
    period_d  = period_q;
    period_wr = 1'b0;
    if (req.wr && req.addr == ADDR_BLINK_MASK) mask_d = wd;
    if (req.wr && req.addr == ADDR_BLINK_PERIOD) begin
      period_d  = req.data[PERIOD_W-1:0];
      period_wr = 1'b1;
    end
  end

  // Blink configuration flops.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mask_q   <= '0;
      period_q <= '0;
    end else begin
      mask_q   <= mask_d;
      period_q <= period_d;
    end
  end

  nios_128k_extended_blink_timer #(
    .PRESCALE (PRESCALE)
  ) u_blink (
    .clk     (clk),
    .reset_n (reset_n),
    .period  (period_q),
    .clear   (period_wr),
    .phase   (phase)
  );

  assign out_port = data_q ^ (mask_q & {WIDTH{phase}});
`else
  assign phase    = 1'b0;
  assign out_port = data_q;
`endif

  // DATA register with direct load plus bitwise set/clear aliases.
  always_comb begin
    data_d = data_q;
    if (req.wr) begin
      case (req.addr)
        ADDR_DATA:     data_d = wd;
        ADDR_OUTSET:   data_d = data_q | wd;
        ADDR_OUTCLEAR: data_d = data_q & ~wd;
        default:       data_d = data_q;
      endcase
    end
  end

  // Read mux: sampled every edge from the live address, chipselect not needed.
  always_comb begin
    readdata_d = '0;
    case (address)
      ADDR_DATA:         readdata_d = 32'(data_q);
`ifdef LED_OUT_BLINK_EN
      ADDR_BLINK_MASK:   readdata_d = 32'(mask_q);
      ADDR_BLINK_PERIOD: readdata_d = 32'(period_q);
      ADDR_STATUS:       readdata_d = {31'b0, phase};
`endif
      default:           readdata_d = '0;
    endcase
  end

  // DATA and read data flops.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_q     <= RESET_VALUE;
      readdata_q <= '0;
    end else begin
      data_q     <= data_d;
      readdata_q <= readdata_d;
    end
  end

  assign readdata = readdata_q;

endmodule

// File: tb/tb_nios_128k_extended_led_out.sv
// Self-checking bench for nios_128k_extended_led_out (WIDTH=4, PRESCALE=4,
// RESET_VALUE=5). Follows LED_OUT_BLINK_EN like the design does.
module tb_nios_128k_extended_led_out;

  localparam int P = 4;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [2:0]  address = '0;
  logic        chipselect = 1'b0;
  logic        write_n = 1'b1;
  logic [31:0] writedata = '0;
  logic [31:0] readdata;
  logic [3:0]  out_port;

  int checks = 0;
  int errors = 0;

  // Reference model state: registers plus clock edges since the last period write.
  logic [3:0]  m_data;
  logic [3:0]  m_mask;
  int          m_period;
  int          m_n;
  logic [31:0] exp_rd;

  nios_128k_extended_led_out #(
    .WIDTH       (4),
    .PRESCALE    (P),
    .RESET_VALUE (4'h5)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .out_port   (out_port)
  );

  always #5 clk = ~clk;

  function automatic logic m_phase();
`ifdef LED_OUT_BLINK_EN
    if (m_period == 0) return 1'b0;
    return ((m_n / (P * m_period)) % 2) == 1;
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [3:0] m_out();
    return m_data ^ (m_mask & {4{m_phase()}});
  endfunction

  function automatic logic [31:0] m_read(input logic [2:0] a);
    case (a)
      3'd0: return {28'b0, m_data};
`ifdef LED_OUT_BLINK_EN
      3'd1: return {28'b0, m_mask};
      3'd2: return 32'(m_period);
      3'd3: return {31'b0, m_phase()};
`endif
      default: return 32'b0;
    endcase
  endfunction

  task automatic model_reset();
    m_data = 4'h5; m_mask = '0; m_period = 0; m_n = 0;
  endtask

  // Advance one clock with the currently driven inputs and update the model.
  task automatic step();
    logic [31:0] rd;
    logic        pwr;
    rd  = m_read(address);
    pwr = 1'b0;
    @(posedge clk); #1;
    if (chipselect && !write_n) begin
      case (address)
        3'd0: m_data = writedata[3:0];
`ifdef LED_OUT_BLINK_EN
        3'd1: m_mask = writedata[3:0];
        3'd2: begin m_period = int'(writedata[15:0]); pwr = 1'b1; end
`endif
        3'd4: m_data = m_data | writedata[3:0];
        3'd5: m_data = m_data & ~writedata[3:0];
        default: ;
      endcase
    end
    m_n    = pwr ? 0 : m_n + 1;
    exp_rd = rd;
  endtask

  task automatic do_write(input logic [2:0] a, input logic [31:0] d);
    address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
    step();
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; model_reset();
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (out_port !== 4'h5) begin errors++; $display("FAIL reset_out got %h want 5", out_port); end
    reset_n = 1'b1;
    checks++;
    if (readdata !== 32'h0) begin errors++; $display("FAIL reset_rd got %h want 0", readdata); end
    checks++;
    if (out_port !== 4'h5) begin errors++; $display("FAIL post_reset_out got %h want 5", out_port); end
    address = 3'd0; step();
    checks++;
    if (readdata !== 32'h5) begin errors++; $display("FAIL reset_read_data got %h want 5", readdata); end
  endtask

  task automatic test_data_ops();
    do_write(3'd0, 32'hFFFF_FFFA);
    checks++;
    if (out_port !== 4'hA) begin errors++; $display("FAIL data_write got %h want a", out_port); end
    do_write(3'd4, 32'h1);
    checks++;
    if (out_port !== 4'hB) begin errors++; $display("FAIL outset got %h want b", out_port); end
    do_write(3'd5, 32'h8);
    checks++;
    if (out_port !== 4'h3) begin errors++; $display("FAIL outclear got %h want 3", out_port); end
    address = 3'd0; step();
    checks++;
    if (readdata !== 32'h3) begin errors++; $display("FAIL read_data got %h want 3", readdata); end
    // Reserved / status writes must not disturb DATA.
    do_write(3'd3, 32'hF); do_write(3'd6, 32'hF); do_write(3'd7, 32'hF);
    checks++;
    if (out_port !== 4'h3) begin errors++; $display("FAIL reserved_write got %h want 3", out_port); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      logic [2:0]  a;
      logic [31:0] d;
      a = 3'($urandom_range(0, 7));
      d = $urandom;
      if (a == 3'd2) d = {d[31:16], 14'b0, d[1:0]};
      if ($urandom_range(0, 2) == 0) do_write(a, d);
      else begin
        address = a; writedata = d; chipselect = 1'($urandom_range(0, 1));
        step();
      end
      checks++;
      if (out_port !== m_out()) begin errors++; $display("FAIL rand_out i=%0d got %h want %h", i, out_port, m_out()); end
      checks++;
      if (readdata !== exp_rd) begin errors++; $display("FAIL rand_rd i=%0d got %h want %h", i, readdata, exp_rd); end
    end
    chipselect = 1'b0;
  endtask

  task automatic test_async_reset();
    do_write(3'd0, 32'hC);
`ifdef LED_OUT_BLINK_EN
    do_write(3'd1, 32'hF);
    do_write(3'd2, 32'h1);
    repeat (6) step();
`endif
    address = 3'd0; step();
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if (out_port !== 4'h5) begin errors++; $display("FAIL async_reset_out got %h want 5", out_port); end
    checks++;
    if (readdata !== 32'h0) begin errors++; $display("FAIL async_reset_rd got %h want 0", readdata); end
    @(posedge clk); #1;
    reset_n = 1'b1; model_reset();
    address = 3'd3; step();
    checks++;
    if (out_port !== 4'h5) begin errors++; $display("FAIL after_reset_out got %h want 5", out_port); end
    checks++;
    if (readdata !== 32'h0) begin errors++; $display("FAIL after_reset_status got %h want 0", readdata); end
  endtask

`ifdef LED_OUT_BLINK_EN
  task automatic test_blink();
    int toggles;
    logic [3:0] prev;
    do_write(3'd0, 32'h0);
    do_write(3'd1, 32'h3);
    do_write(3'd2, 32'h3);
    address = 3'd3;
    toggles = 0;
    prev = out_port;
    for (int i = 1; i <= 48; i++) begin
      step();
      checks++;
      if (out_port !== m_out()) begin errors++; $display("FAIL blink_out i=%0d got %h want %h", i, out_port, m_out()); end
      if (out_port !== prev) toggles++;
      prev = out_port;
      if (i % 12 == 0) begin
        checks++;
        if (out_port !== ((i / 12) % 2 == 1 ? 4'h3 : 4'h0)) begin
          errors++; $display("FAIL blink_edge i=%0d got %h", i, out_port);
        end
      end
      if (i >= 2) begin
        checks++;
        if (readdata !== exp_rd) begin errors++; $display("FAIL blink_status i=%0d got %h want %h", i, readdata, exp_rd); end
      end
    end
    checks++;
    if (toggles !== 4) begin errors++; $display("FAIL blink_toggle_count got %0d want 4", toggles); end
  endtask

  task automatic test_period_rewrite();
    int guard;
    guard = 0;
    while (!m_phase() && guard < 100) begin step(); guard++; end
    checks++;
    if (out_port !== 4'h3) begin errors++; $display("FAIL rewrite_pre got %h want 3", out_port); end
    do_write(3'd2, 32'h3);
    checks++;
    if (out_port !== 4'h0) begin errors++; $display("FAIL rewrite_clear got %h want 0", out_port); end
    for (int i = 1; i <= 12; i++) begin
      step();
      checks++;
      if (out_port !== (i == 12 ? 4'h3 : 4'h0)) begin
        errors++; $display("FAIL rewrite_next i=%0d got %h", i, out_port);
      end
    end
  endtask

  task automatic test_blink_off();
    do_write(3'd0, 32'h6);
    do_write(3'd1, 32'hF);
    do_write(3'd2, 32'h0);
    for (int i = 0; i < 1000; i++) begin
      step();
      checks++;
      if (out_port !== 4'h6) begin errors++; $display("FAIL blink_off i=%0d got %h want 6", i, out_port); end
    end
  endtask
`else
  task automatic test_no_blink();
    do_write(3'd0, 32'h9);
    do_write(3'd1, 32'hF);
    do_write(3'd2, 32'h1);
    address = 3'd1; step(); step();
    checks++;
    if (readdata !== 32'h0) begin errors++; $display("FAIL noblink_mask_rd got %h want 0", readdata); end
    address = 3'd2; step(); step();
    checks++;
    if (readdata !== 32'h0) begin errors++; $display("FAIL noblink_period_rd got %h want 0", readdata); end
    for (int i = 0; i < 40; i++) begin
      step();
      checks++;
      if (out_port !== 4'h9) begin errors++; $display("FAIL noblink_out i=%0d got %h want 9", i, out_port); end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_data_ops();
`ifdef LED_OUT_BLINK_EN
    test_blink();
    test_period_rewrite();
    test_blink_off();
`else
    test_no_blink();
`endif
    test_random();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/nios_128k_extended_led_out.md
NIOS_128K_EXTENDED_LED_OUT -- requirements
Module: nios_128k_extended_led_out

Interface
REQ-001 SHALL have parameter WIDTH, default 4, giving the output port width in bits (1..32).
REQ-002 SHALL have parameter PRESCALE, default 50000, giving clk cycles per blink tick (>=2).
REQ-003 SHALL have parameter RESET_VALUE, default 0, giving the DATA reset value.
REQ-004 clk  input  1  system clock; all state on rising edge.
REQ-005 reset_n  input  1  asynchronous, active-low reset.
REQ-006 address  input  3  word address of the Avalon-MM slave s1.
REQ-007 chipselect  input  1  slave select.
REQ-008 write_n  input  1  active-low write strobe; a write occurs when chipselect=1 and write_n=0.
REQ-009 writedata  input  32  write data.
REQ-010 readdata  output  32  registered read data.
REQ-011 out_port  output  WIDTH  driven pins (LEDs).

Function
REQ-012 Register map: 0 DATA (R/W), 1 BLINK_MASK (R/W, WIDTH bits), 2 BLINK_PERIOD (R/W, 16 bits), 3 STATUS (RO: bit0 = phase), 4 OUTSET (WO), 5 OUTCLEAR (WO), 6-7 reserved.
REQ-013 Write to 0/1 SHALL load writedata[WIDTH-1:0]; write to 2 SHALL load writedata[15:0]; upper bits ignored.
REQ-014 Write to OUTSET SHALL perform DATA <= DATA | writedata[WIDTH-1:0]; OUTCLEAR SHALL perform DATA <= DATA & ~writedata[WIDTH-1:0].
REQ-015 Writes to 3, 6, 7 SHALL have no effect.
REQ-016 readdata SHALL update every clk edge, independent of chipselect, from the current address: 0 DATA, 1 BLINK_MASK, 2 BLINK_PERIOD, 3 {31'b0, phase}, 4-7 zero; zero-extended; read latency 1 cycle.
REQ-017 out_port SHALL equal DATA ^ (BLINK_MASK & {WIDTH{phase}}), built only from register outputs (no writedata path); a write is visible on out_port the cycle after its accepted edge.
REQ-018 Prescaler SHALL count 0..PRESCALE-1 and wrap, asserting a one-cycle tick on the wrap.
REQ-019 When BLINK_PERIOD != 0, the tick counter SHALL increment on each tick; when it reaches BLINK_PERIOD-1 on a tick it SHALL clear and phase SHALL toggle.
REQ-020 When BLINK_PERIOD = 0, phase and tick counter SHALL be held at 0 (blink off).
REQ-021 A write to BLINK_PERIOD SHALL clear prescaler, tick counter and phase in the same edge, overriding any coincident tick.
REQ-022 A DATA/OUTSET/OUTCLEAR/BLINK_MASK write coincident with a phase toggle SHALL apply both: new register value and toggled phase.
REQ-023 Phase toggling SHALL continue with BLINK_MASK = 0; only out_port is unaffected.

Reset
REQ-024 On reset_n=0: DATA=RESET_VALUE, BLINK_MASK=0, BLINK_PERIOD=0, phase=0, prescaler=0, tick counter=0, readdata=0; out_port=RESET_VALUE.
REQ-025 Reset asserted mid-blink SHALL take effect immediately (asynchronous); the first post-reset cycle SHALL behave as after power-up.

Configuration
REQ-026 Macro LED_OUT_BLINK_EN defined: blink engine (REQ-018..023), registers 1-3 as specified.
REQ-027 Macro LED_OUT_BLINK_EN undefined: no prescaler/counter/phase logic; addresses 1-3 read 0, writes ignored; out_port = DATA.

Structure
REQ-028 Register address constants (ADDR_DATA..ADDR_OUTCLEAR) and the 16-bit period width SHALL reside in shared package nios_128k_extended_pio_pkg.
REQ-029 Blink engine (prescaler, tick counter, phase) SHALL be sub-module nios_128k_extended_blink_timer, instantiated only under LED_OUT_BLINK_EN.

Verification
REQ-030 Reset with RESET_VALUE=4'h5 -> out_port=4'h5, readdata=0 the first cycle after release.
REQ-031 Write DATA=0xA, then OUTSET=0x1, then OUTCLEAR=0x8 -> out_port 0xA, 0xB, 0x3 on successive cycles; read addr 0 -> 0x3 after 1 cycle.
REQ-032 PRESCALE=4, BLINK_PERIOD=3, BLINK_MASK=0x3, DATA=0x0 -> out_port toggles 0x0/0x3 every 12 clk; STATUS bit0 tracks it.
REQ-033 Rewrite BLINK_PERIOD=3 while phase=1 -> phase=0 and out_port=DATA next cycle; next toggle 12 clk later.
REQ-034 BLINK_PERIOD=0 with BLINK_MASK=0xF -> out_port constant = DATA for 1000 clk.
REQ-035 Build without LED_OUT_BLINK_EN: write 0xF to address 1 -> read address 1 returns 0, out_port = DATA.
